// File: rtl/temporizador_pkg.sv
// ============================================================================
// Module      : temporizador_pkg
// Description : Shared constants for the programmable timer: FSM state
//               encoding and operating-mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package temporizador_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Mode latched at start
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage : temporizador_pkg

`default_nettype wire

// File: rtl/temporizador_prog_if.sv
// ============================================================================
// Module      : temporizador_prog_if
// Description : Control/status bundle of the programmable timer. The irq and
//               irq_clr members exist only when TEMPORIZADOR_IRQ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface temporizador_prog_if #(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
);
    logic               start;
    logic               stop;
    logic               periodic;
    logic [WIDTH-1:0]   load_val;
    logic [PRESC_W-1:0] presc_val;
    logic               busy;
    logic               tick;
    logic               saidaq;
    logic [WIDTH-1:0]   count;
`ifdef TEMPORIZADOR_IRQ_EN
    logic               irq;
    logic               irq_clr;

    modport master (
        output start, stop, periodic, load_val, presc_val, irq_clr,
        input  busy, tick, saidaq, count, irq
    );
    modport slave (
        input  start, stop, periodic, load_val, presc_val, irq_clr,
        output busy, tick, saidaq, count, irq
    );
`else
    modport master (
        output start, stop, periodic, load_val, presc_val,
        input  busy, tick, saidaq, count
    );
    modport slave (
        input  start, stop, periodic, load_val, presc_val,
        output busy, tick, saidaq, count
    );
`endif
endinterface : temporizador_prog_if

`default_nettype wire

// File: rtl/prescaler_sync.sv
// ============================================================================
// Module      : prescaler_sync
// Description : Synchronous reloadable prescaler. Counts the latched reload
//               value P down to 0 and emits a step on the cycle pc==0, giving
//               one step every P+1 enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prescaler_sync #(
    parameter int PRESC_W = 8
) (
    input  wire logic               clkf,
    input  wire logic               rst,
    input  wire logic               load_i,       // accepted start: latch P
    input  wire logic               clr_i,        // stop: abandon current count
    input  wire logic               en_i,         // timer in RUN
    input  wire logic [PRESC_W-1:0] presc_val_i,
    output logic                    step_o
);

    logic [PRESC_W-1:0] pc_q;
    logic [PRESC_W-1:0] pc_d;
    logic [PRESC_W-1:0] reload_q;
    logic [PRESC_W-1:0] reload_d;

    assign step_o = en_i && (pc_q == '0);

    // Next prescaler value: clear on stop, load on start, else count/reload
    always_comb begin
        pc_d     = pc_q;
        reload_d = reload_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (load_i) begin
            pc_d     = presc_val_i;
            reload_d = presc_val_i;
        end else if (en_i) begin
            if (pc_q == '0) begin
                pc_d = reload_q;
            end else begin
                pc_d = pc_q - PRESC_W'(1);
            end
        end
    end

    // Prescaler registers with synchronous reset
    always_ff @(posedge clkf) begin
        if (rst) begin
            pc_q     <= '0;
            reload_q <= '0;
        end else begin
            pc_q     <= pc_d;
            reload_q <= reload_d;
        end
    end

endmodule : prescaler_sync

`default_nettype wire

// File: rtl/temporizador_prog.sv
// ============================================================================
// Module      : temporizador_prog
// Description : Programmable synchronous timer: prescaler plus down-counter,
//               one-shot or periodic, with tick pulse, square-wave output and
//               live count. Optional sticky interrupt flag enabled by the
//               TEMPORIZADOR_IRQ_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module temporizador_prog
    import temporizador_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  wire logic          clkf,
    input  wire logic          rst,
    temporizador_prog_if.slave bus
);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] load_d;
    logic             mode_q;
    logic             mode_d;
    logic             tick_q;
    logic             tick_d;
    logic             saidaq_q;
    logic             saidaq_d;
    logic             step;
    logic             expiry;

    // Stop has priority over start, so the prescaler only loads on a start
    // that is not overridden.
    prescaler_sync #(
        .PRESC_W     (PRESC_W)
    ) u_presc (
        .clkf        (clkf),
        .rst         (rst),
        .load_i      (bus.start && !bus.stop),
        .clr_i       (bus.stop),
        .en_i        (state_q == ST_RUN),
        .presc_val_i (bus.presc_val),
        .step_o      (step)
    );

    // FSM and main counter next state; stop > start > expiry
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load_d   = load_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        saidaq_d = saidaq_q;
        expiry   = 1'b0;
        if (bus.stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
        end else if (bus.start) begin
            state_d = ST_RUN;
            count_d = bus.load_val;
            load_d  = bus.load_val;
            mode_d  = bus.periodic;
        end else if ((state_q == ST_RUN) && step) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                expiry   = 1'b1;
                tick_d   = 1'b1;
                saidaq_d = ~saidaq_q;
                if (mode_q == MODE_PERIODIC) begin
                    count_d = load_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clkf) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            load_q   <= '0;
            mode_q   <= MODE_ONESHOT;
            tick_q   <= 1'b0;
            saidaq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            load_q   <= load_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            saidaq_q <= saidaq_d;
        end
    end

    assign bus.busy   = (state_q == ST_RUN);
    assign bus.tick   = tick_q;
    assign bus.saidaq = saidaq_q;
    assign bus.count  = count_q;

`ifdef TEMPORIZADOR_IRQ_EN
    logic irq_q;
    logic irq_d;

    // Sticky interrupt flag: a new expiry wins over a coincident clear
    always_comb begin
        irq_d = irq_q;
        if (expiry) begin
            irq_d = 1'b1;
        end else if (bus.irq_clr) begin
            irq_d = 1'b0;
        end
    end

    // Interrupt flag register with synchronous reset
    always_ff @(posedge clkf) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`endif

endmodule : temporizador_prog

`default_nettype wire
